instr_stream_encoder: RTL and testbench

Sequential instruction encoder for the single-cycle MIPS core: the inverse of the main decoder. Accepts one symbolic instruction per handshake (mnemonic + register/immediate fields), encodes it into a 32-bit word using the core's opcode/func map, and writes it into consecutive instruction-memory locations. Used by testbenches and the boot loader to build programs in place, so every emitted word is decodable by the core's controller.

---
 rtl/instr_pkg.sv | 64 ++++++
 rtl/instr_field_packer.sv | 40 ++++
 rtl/instr_stream_encoder.sv | 111 +++++++++++
 tb/tb_instr_stream_encoder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_pkg.sv
// Shared encoding tables for the single-cycle MIPS core:
// mnemonics, opcode/func maps, fixed words and encoder FSM states.
package instr_pkg;

    typedef enum logic [3:0] {
        MN_ADD  = 4'd0,
        MN_SUB  = 4'd1,
        MN_AND  = 4'd2,
        MN_OR   = 4'd3,
        MN_SLT  = 4'd4,
        MN_ADDI = 4'd5,
        MN_SLTI = 4'd6,
        MN_LW   = 4'd7,
        MN_SW   = 4'd8,
        MN_BEQ  = 4'd9,
        MN_J    = 4'd10,
        MN_JR   = 4'd11,
        MN_JAL  = 4'd12,
        MN_NOP  = 4'd13,
        MN_HALT = 4'd14,
        MN_ILL  = 4'd15
    } mnem_e;

    localparam logic [5:0] OPC_RT   = 6'd0;
    localparam logic [5:0] OPC_ADDI = 6'd1;
    localparam logic [5:0] OPC_SLTI = 6'd2;
    localparam logic [5:0] OPC_LW   = 6'd3;
    localparam logic [5:0] OPC_SW   = 6'd4;
    localparam logic [5:0] OPC_BEQ  = 6'd5;
    localparam logic [5:0] OPC_J    = 6'd6;
    localparam logic [5:0] OPC_JR   = 6'd7;
    localparam logic [5:0] OPC_JAL  = 6'd8;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [31:0] NOP_WORD = 32'h0000_0020;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    function automatic logic [31:0] enc_r(
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic [4:0] rd,
        input logic [5:0] fn
    );
        return {OPC_RT, rs, rt, rd, 5'b0, fn};
    endfunction

    function automatic logic [31:0] enc_i(
        input logic [5:0]  opc,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [15:0] imm
    );
        return {opc, rs, rt, imm};
    endfunction

endpackage

// File: rtl/instr_field_packer.sv
// Combinational mnemonic + fields to 32-bit MIPS word.
// HALT jumps to its own word index, hence the address input.
module instr_field_packer
    import instr_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [4:0]  rs_i,
    input  logic [4:0]  rt_i,
    input  logic [4:0]  rd_i,
    input  logic [15:0] imm_i,
    input  logic [25:0] target_i,
    input  logic [25:0] pc_word_i,
    output logic [31:0] word_o,
    output logic        legal_o
);

    always_comb begin
        word_o  = '0;
        legal_o = 1'b1;
        case (mnem_e'(op_i))
            MN_ADD:  word_o = enc_r(rs_i, rt_i, rd_i, FN_ADD);
            MN_SUB:  word_o = enc_r(rs_i, rt_i, rd_i, FN_SUB);
            MN_AND:  word_o = enc_r(rs_i, rt_i, rd_i, FN_AND);
            MN_OR:   word_o = enc_r(rs_i, rt_i, rd_i, FN_OR);
            MN_SLT:  word_o = enc_r(rs_i, rt_i, rd_i, FN_SLT);
            MN_ADDI: word_o = enc_i(OPC_ADDI, rs_i, rt_i, imm_i);
            MN_SLTI: word_o = enc_i(OPC_SLTI, rs_i, rt_i, imm_i);
            MN_LW:   word_o = enc_i(OPC_LW, rs_i, rt_i, imm_i);
            MN_SW:   word_o = enc_i(OPC_SW, rs_i, rt_i, imm_i);
            MN_BEQ:  word_o = enc_i(OPC_BEQ, rs_i, rt_i, imm_i);
            MN_J:    word_o = {OPC_J, target_i};
            MN_JR:   word_o = {OPC_JR, rs_i, 21'b0};
            MN_JAL:  word_o = {OPC_JAL, target_i};
            MN_NOP:  word_o = NOP_WORD;
            MN_HALT: word_o = {OPC_J, pc_word_i};
            default: legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_stream_encoder.sv
// Accepts symbolic instructions one per handshake and writes the
// encoded words into consecutive instruction-memory locations.
module instr_stream_encoder
    import instr_pkg::*;
#(
    parameter int          DEPTH_LOG2 = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            in_op,
    input  logic [4:0]            in_rs,
    input  logic [4:0]            in_rt,
    input  logic [4:0]            in_rd,
    input  logic [15:0]           in_imm,
    input  logic [25:0]           in_target,
    output logic                  imem_we,
    output logic [31:0]           imem_addr,
    output logic [31:0]           imem_wdata,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  err
);

    localparam logic [DEPTH_LOG2:0] CAP =
        {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [1:0]            state_q, state_d;
    logic [DEPTH_LOG2-1:0] ptr_q, ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  err_q, err_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           pack_word;
    logic                  pack_legal;

    assign imem_addr  = BASE_ADDR + 32'({ptr_q, 2'b00});
    assign imem_wdata = wdata_q;
    assign imem_we    = (state_q == ST_WRITE);
    assign in_ready   = (state_q == ST_IDLE) && !rst;
    assign count      = count_q;
    assign full       = (count_q == CAP);
    assign err        = err_q;

    instr_field_packer u_packer (
        .op_i      (in_op),
        .rs_i      (in_rs),
        .rt_i      (in_rt),
        .rd_i      (in_rd),
        .imm_i     (in_imm),
        .target_i  (in_target),
        .pc_word_i (imem_addr[27:2]),
        .word_o    (pack_word),
        .legal_o   (pack_legal)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        err_d   = err_q;
        wdata_d = wdata_q;
        if (clear) begin
            // an in-flight write still strobes this cycle
            state_d = ST_IDLE;
            ptr_d   = '0;
            count_d = '0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid && pack_legal) begin
                        wdata_d = pack_word;
                        state_d = ST_WRITE;
                    end else if (in_valid) begin
                        err_d = 1'b1;
                    end
                end
                ST_WRITE: begin
                    count_d = count_q + (DEPTH_LOG2+1)'(1);
                    // saturate so the last slot address is held
                    if (!(&ptr_q))
                        ptr_d = ptr_q + (DEPTH_LOG2)'(1);
                    state_d = (count_d == CAP) ? ST_FULL
                                               : ST_IDLE;
                end
                ST_FULL: state_d = ST_FULL;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            err_q   <= err_d;
            wdata_q <= wdata_d;
        end
    end

endmodule

// File: tb/tb_instr_stream_encoder.sv
// Directed-vector bench with a write scoreboard for
// instr_stream_encoder (4-word memory at byte 0x100).
module tb_instr_stream_encoder;

    localparam int          D    = 2;
    localparam logic [31:0] BASE = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [4:0]  in_rs, in_rt, in_rd;
    logic [15:0] in_imm;
    logic [25:0] in_target;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic [D:0]  count;
    logic        full;
    logic        err;

    int vectors = 0;
    int miscompares = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    instr_stream_encoder #(
        .DEPTH_LOG2 (D),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rs      (in_rs),
        .in_rt      (in_rt),
        .in_rd      (in_rd),
        .in_imm     (in_imm),
        .in_target  (in_target),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .count      (count),
        .full       (full),
        .err        (err)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (imem_we) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write: got addr %h data %h required no write",
                         imem_addr, imem_wdata);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                chk("wr_addr", imem_addr, e[63:32]);
                chk("wr_data", imem_wdata, e[31:0]);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear;
        @(negedge clk);
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic drive(input logic [3:0] op, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd,
                         input logic [15:0] imm,
                         input logic [25:0] tg);
        in_op = op;
        in_rs = rs;
        in_rt = rt;
        in_rd = rd;
        in_imm = imm;
        in_target = tg;
    endtask

    task automatic send(input logic [3:0] op, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd,
                        input logic [15:0] imm,
                        input logic [25:0] tg,
                        input logic [31:0] ea,
                        input logic [31:0] ed);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL ready_timeout: got in_ready 0 required 1");
            return;
        end
        drive(op, rs, rt, rd, imm, tg);
        in_valid = 1'b1;
        exp_q.push_back({ea, ed});
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        clear = 1'b0;
        in_valid = 1'b0;
        drive(4'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_we", 32'(imem_we), 32'd0);
        chk("rst_addr", imem_addr, BASE);
        chk("rst_wdata", imem_wdata, 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 32'(in_ready), 32'd1);

        // ADD $3,$1,$2
        send(4'd0, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0,
             32'h100, 32'h0022_1820);
        tick();
        chk("count_add", 32'(count), 32'd1);

        do_clear();
        send(4'd7, 5'd0, 5'd4, 5'd0, 16'h0008, 26'd0,
             32'h100, 32'h0C04_0008);
        send(4'd9, 5'd4, 5'd5, 5'd0, 16'hFFFF, 26'd0,
             32'h104, 32'h1485_FFFF);
        send(4'd11, 5'd31, 5'd0, 5'd0, 16'd0, 26'd0,
             32'h108, 32'h1FE0_0000);
        tick();
        chk("count_seq", 32'(count), 32'd3);

        do_clear();
        send(4'd13, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0,
             32'h100, 32'h0000_0020);
        send(4'd13, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0,
             32'h104, 32'h0000_0020);
        send(4'd13, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0,
             32'h108, 32'h0000_0020);
        send(4'd14, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0,
             32'h10C, 32'h1800_0043);
        tick();
        chk("count_halt", 32'(count), 32'd4);
        chk("full_halt", 32'(full), 32'd1);
        chk("ready_halt", 32'(in_ready), 32'd0);

        do_clear();
        chk("count_clr", 32'(count), 32'd0);
        chk("full_clr", 32'(full), 32'd0);
        chk("ready_clr", 32'(in_ready), 32'd1);

        // ADDI $2,$1,5 held for 6 request slots
        @(negedge clk);
        drive(4'd5, 5'd1, 5'd2, 5'd0, 16'd5, 26'd0);
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++)
            exp_q.push_back({BASE + 32'(i * 4), 32'h0422_0005});
        repeat (12) @(negedge clk);
        in_valid = 1'b0;
        chk("count_hold", 32'(count), 32'd4);
        chk("full_hold", 32'(full), 32'd1);
        chk("ready_hold", 32'(in_ready), 32'd0);
        chk("we_hold", 32'(imem_we), 32'd0);

        // illegal mnemonic
        do_clear();
        @(negedge clk);
        drive(4'd15, 5'd1, 5'd1, 5'd1, 16'd1, 26'd1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("err_set", 32'(err), 32'd1);
        repeat (2) @(negedge clk);
        chk("err_sticky", 32'(err), 32'd1);
        chk("count_ill", 32'(count), 32'd0);
        chk("ready_ill", 32'(in_ready), 32'd1);
        do_clear();
        chk("err_clr", 32'(err), 32'd0);
        send(4'd8, 5'd2, 5'd7, 5'd0, 16'h0010, 26'd0,
             32'h100, 32'h1047_0010);
        send(4'd10, 5'd0, 5'd0, 5'd0, 16'd0, 26'h0000123,
             32'h104, 32'h1800_0123);
        send(4'd12, 5'd0, 5'd0, 5'd0, 16'd0, 26'h2ABCDEF,
             32'h108, 32'h22AB_CDEF);
        send(4'd1, 5'd3, 5'd4, 5'd5, 16'd0, 26'd0,
             32'h10C, 32'h0064_2822);
        tick();
        chk("count_mix", 32'(count), 32'd4);

        // reset in the middle of a write
        do_clear();
        send(4'd0, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0,
             32'h100, 32'h0022_1820);
        @(negedge clk);
        @(negedge clk);
        drive(4'd2, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("we_in_write", 32'(imem_we), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("we_abort", 32'(imem_we), 32'd0);
        chk("ready_in_rst", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("count_post_rst", 32'(count), 32'd0);
        chk("addr_post_rst", imem_addr, BASE);
        chk("wdata_post_rst", imem_wdata, 32'd0);
        chk("ready_post_rst", 32'(in_ready), 32'd1);

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
